oam_dma: RTL and testbench

//  Bus initiator for OAM DMA. CPU writes page P to FF46; the block then reads P00..P9F and copies each byte into OAM FE00..FE9F.
//  It sits beside the system address decoder and consumes that decoder's ffxx and cpu_wr/cpu_rd strobes.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_xfer_ctr.sv | 34 +++
 rtl/oam_dma.sv | 123 ++++++++++++
 tb/tb_oam_dma.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared constants, FSM state type and the echo-RAM source helper for the OAM DMA block.
package dma_pkg;

  localparam int         DMA_LEN     = 160;
  localparam int         START_DELAY = 1;
  localparam logic [7:0] REG_LO      = 8'h46;
  localparam logic [7:0] ECHO_BASE   = 8'hE0;
  localparam logic [7:0] ECHO_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } dma_state_e;

  // Pages E0..FF alias work RAM at C0..DF, so they fold down by 0x20.
  function automatic logic [7:0] src_hi(input logic [7:0] page);
    return (page < ECHO_BASE) ? page : page - ECHO_OFFSET;
  endfunction

endpackage

// File: rtl/dma_xfer_ctr.sv
// Byte index counter for one OAM transfer; wraps to zero after the last byte.
module dma_xfer_ctr #(
  parameter int LEN = 160
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  output logic [7:0] idx,
  output logic       last
);

  logic [7:0] idx_q, idx_d;

  assign last = (idx_q == 8'(LEN - 1));
  assign idx  = idx_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = last ? '0 : idx_q + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

endmodule

// File: rtl/oam_dma.sv
// OAM DMA initiator: a write to FF46 copies page P00..P9F into OAM FE00..FE9F.
// Holds the page register, FSM, OAM write pipeline and the FF46 read driver.
module oam_dma
  import dma_pkg::*;
(
  input  logic        clk,
  input  logic        nreset2,
  input  logic [15:0] a,
  inout  wire  [7:0]  d,
  input  logic        ffxx,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  src_rdata,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr,
  output logic        dma_active,
  output logic        cpu_block
);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] src_q, src_d;
  logic       run_q, run_d;
  logic [3:0] dly_q, dly_d;
  logic       wr_q, wr_d;
  logic [7:0] waddr_q, waddr_d;

  logic       reg_hit, reg_wr, reg_rd;
  logic       rd_en, idx_clr, idx_last;
  logic [7:0] idx;

  assign reg_hit = ffxx && (a == {8'hFF, REG_LO});
  assign reg_wr  = reg_hit && cpu_wr;
  assign reg_rd  = reg_hit && cpu_rd;

  // Reads also continue during a restart's START cycles while an old transfer is still in flight.
  assign rd_en = (state_q == XFER) || ((state_q == START) && run_q);

  dma_xfer_ctr #(
    .LEN (DMA_LEN)
  ) u_ctr (
    .clk   (clk),
    .rst_n (nreset2),
    .clr   (idx_clr),
    .en    (rd_en),
    .idx   (idx),
    .last  (idx_last)
  );

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    src_d   = src_q;
    run_d   = run_q;
    dly_d   = dly_q;
    idx_clr = 1'b0;
    wr_d    = rd_en;
    waddr_d = idx;

    unique case (state_q)
      IDLE: ;
      START: begin
        if (run_q && idx_last) run_d = 1'b0;
        if (dly_q == 4'(START_DELAY - 1)) begin
          state_d = XFER;
          idx_clr = 1'b1;
          src_d   = src_hi(page_q);
          run_d   = 1'b0;
        end else begin
          dly_d = dly_q + 4'd1;
        end
      end
      XFER: begin
        if (idx_last) state_d = DRAIN;
      end
      DRAIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A register write from any state (re)starts the delay; the old stream keeps issuing until it finishes or START ends.
    if (reg_wr) begin
      page_d  = d;
      state_d = START;
      dly_d   = '0;
      idx_clr = 1'b0;
      run_d   = rd_en && !idx_last;
    end
  end

  always_ff @(posedge clk or negedge nreset2) begin
    if (!nreset2) begin
      state_q <= IDLE;
      page_q  <= '0;
      src_q   <= '0;
      run_q   <= 1'b0;
      dly_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      src_q   <= src_d;
      run_q   <= run_d;
      dly_q   <= dly_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
    end
  end

  assign dma_rd     = rd_en;
  assign dma_addr   = rd_en ? {src_q, idx} : 16'h0000;
  assign oam_wr     = wr_q;
  assign oam_addr   = wr_q ? waddr_q : 8'h00;
  assign oam_wdata  = wr_q ? src_rdata : 8'h00;
  assign dma_active = (state_q != IDLE);
  assign cpu_block  = dma_active && !ffxx;

  assign d = reg_rd ? page_q : 8'hzz;

endmodule

// File: tb/tb_oam_dma.sv
// Directed self-checking bench for oam_dma: timing, echo alias, restart, drain retrigger, reset and decode.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        nreset2;
  logic [15:0] a;
  tri1  [7:0]  d;
  logic        ffxx, cpu_wr, cpu_rd;
  logic [7:0]  src_rdata = 8'h00;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_wr, dma_active, cpu_block;

  logic        tb_d_en;
  logic [7:0]  tb_d;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          oam_cnt = 0;
  int          n, m;

  assign d = tb_d_en ? tb_d : 8'hzz;

  oam_dma dut (
    .clk        (clk),
    .nreset2    (nreset2),
    .a          (a),
    .d          (d),
    .ffxx       (ffxx),
    .cpu_wr     (cpu_wr),
    .cpu_rd     (cpu_rd),
    .src_rdata  (src_rdata),
    .dma_addr   (dma_addr),
    .dma_rd     (dma_rd),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_wr     (oam_wr),
    .dma_active (dma_active),
    .cpu_block  (cpu_block)
  );

  always #5 clk = ~clk;

  // Source memory: byte at address A is A[15:8]^A[7:0], returned the cycle after the read.
  always @(posedge clk) src_rdata <= dma_rd ? (dma_addr[15:8] ^ dma_addr[7:0]) : 8'h00;

  always @(posedge clk) if (oam_wr) oam_cnt++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic bus_idle();
    a = 16'h0000; ffxx = 1'b0; cpu_wr = 1'b0; cpu_rd = 1'b0; tb_d_en = 1'b0; tb_d = 8'h00;
  endtask

  task automatic set_wr(input logic [15:0] addr, input logic [7:0] v);
    a = addr; ffxx = (addr[15:8] == 8'hFF); cpu_wr = 1'b1; cpu_rd = 1'b0; tb_d_en = 1'b1; tb_d = v;
  endtask

  task automatic set_rd(input logic [15:0] addr);
    a = addr; ffxx = (addr[15:8] == 8'hFF); cpu_wr = 1'b0; cpu_rd = 1'b1; tb_d_en = 1'b0;
  endtask

  initial begin
    bus_idle();
    nreset2 = 1'b0;
    tick(); tick();
    samp();
    check("rst_active", 16'(dma_active), 16'h0);
    check("rst_dma_rd", 16'(dma_rd), 16'h0);
    check("rst_oam_wr", 16'(oam_wr), 16'h0);
    check("rst_dma_addr", dma_addr, 16'h0000);
    nreset2 = 1'b1;
    tick();
    set_rd(16'hFF46); samp();
    check("rst_page_rd", 16'(d), 16'h0000);
    bus_idle(); tick();

    // Page C1: latency, cpu_block, register readback, last write
    oam_cnt = 0;
    set_wr(16'hFF46, 8'hC1); n = cyc; tick(); bus_idle();
    samp();
    check("c1_active_n1", 16'(dma_active), 16'h1);
    check("c1_rd_n1", 16'(dma_rd), 16'h0);
    tick(); samp();
    check("c1_rd_n2", 16'(dma_rd), 16'h1);
    check("c1_addr_n2", dma_addr, 16'hC100);
    check("c1_oamwr_n2", 16'(oam_wr), 16'h0);
    tick(); samp();
    check("c1_oamwr_n3", 16'(oam_wr), 16'h1);
    check("c1_oamaddr_n3", 16'(oam_addr), 16'h00);
    check("c1_oamdata_n3", 16'(oam_wdata), 16'h00C1);
    tick(); a = 16'hFF80; ffxx = 1'b1; samp();
    check("blk_ff80", 16'(cpu_block), 16'h0);
    tick(); a = 16'hC000; ffxx = 1'b0; samp();
    check("blk_c000", 16'(cpu_block), 16'h1);
    tick(); set_rd(16'hFF46); samp();
    check("c1_page_rd", 16'(d), 16'h00C1);
    bus_idle();
    goto(n + 161); samp();
    check("c1_rd_last", 16'(dma_rd), 16'h1);
    check("c1_addr_last", dma_addr, 16'hC19F);
    tick(); samp();
    check("c1_rd_drain", 16'(dma_rd), 16'h0);
    check("c1_oamwr_last", 16'(oam_wr), 16'h1);
    check("c1_oamaddr_last", 16'(oam_addr), 16'h9F);
    check("c1_oamdata_last", 16'(oam_wdata), 16'h005E);
    check("c1_active_last", 16'(dma_active), 16'h1);
    tick(); samp();
    check("c1_active_end", 16'(dma_active), 16'h0);
    check("c1_oamwr_end", 16'(oam_wr), 16'h0);
    check("c1_oam_count", 16'(oam_cnt), 16'd160);

    // Page FE: echo alias to DE
    set_wr(16'hFF46, 8'hFE); n = cyc; tick(); bus_idle();
    goto(n + 2); samp();
    check("fe_addr_first", dma_addr, 16'hDE00);
    goto(n + 161); samp();
    check("fe_addr_last", dma_addr, 16'hDE9F);
    goto(n + 163); samp();
    check("fe_active_end", 16'(dma_active), 16'h0);
    set_rd(16'hFF46); samp();
    check("fe_page_rd", 16'(d), 16'h00FE);
    bus_idle(); tick();

    // Retrigger during DRAIN: final write completes, then START rather than IDLE
    set_wr(16'hFF46, 8'h10); n = cyc; tick(); bus_idle();
    goto(n + 162); samp();
    check("drn_oamaddr", 16'(oam_addr), 16'h9F);
    set_wr(16'hFF46, 8'h20); m = cyc; tick(); bus_idle();
    samp();
    check("drn_active_start", 16'(dma_active), 16'h1);
    check("drn_rd_start", 16'(dma_rd), 16'h0);
    check("drn_oamwr_start", 16'(oam_wr), 16'h0);
    tick(); samp();
    check("drn_addr_first", dma_addr, 16'h2000);
    goto(m + 163); samp();
    check("drn_active_end", 16'(dma_active), 16'h0);

    // Restart at idx 50: old read of idx 51 in START, then new page from idx 0
    set_wr(16'hFF46, 8'h80); n = cyc; tick(); bus_idle();
    goto(n + 52); samp();
    check("rs_addr_idx50", dma_addr, 16'h8032);
    set_wr(16'hFF46, 8'hC0); m = cyc; tick(); bus_idle();
    samp();
    check("rs_rd_start", 16'(dma_rd), 16'h1);
    check("rs_addr_start", dma_addr, 16'h8033);
    check("rs_oamaddr_50", 16'(oam_addr), 16'h32);
    tick(); samp();
    check("rs_addr_new", dma_addr, 16'hC000);
    check("rs_oamaddr_51", 16'(oam_addr), 16'h33);
    check("rs_oamdata_51", 16'(oam_wdata), 16'h00B3);
    tick(); oam_cnt = 0; samp();
    check("rs_oamaddr_0", 16'(oam_addr), 16'h00);
    check("rs_oamdata_0", 16'(oam_wdata), 16'h00C0);
    goto(m + 162); samp();
    check("rs_oamaddr_last", 16'(oam_addr), 16'h9F);
    check("rs_oamdata_last", 16'(oam_wdata), 16'h005F);
    tick(); samp();
    check("rs_active_end", 16'(dma_active), 16'h0);
    check("rs_oam_count", 16'(oam_cnt), 16'd160);

    // Asynchronous reset at idx 20
    set_wr(16'hFF46, 8'h40); n = cyc; tick(); bus_idle();
    goto(n + 22); samp();
    check("ar_addr_idx20", dma_addr, 16'h4014);
    #1 nreset2 = 1'b0;
    #1;
    check("ar_dma_rd", 16'(dma_rd), 16'h0);
    check("ar_oam_wr", 16'(oam_wr), 16'h0);
    check("ar_active", 16'(dma_active), 16'h0);
    check("ar_dma_addr", dma_addr, 16'h0000);
    check("ar_oam_addr", 16'(oam_addr), 16'h00);
    check("ar_oam_wdata", 16'(oam_wdata), 16'h00);
    tick(); tick();
    nreset2 = 1'b1;
    tick();
    set_rd(16'hFF46); samp();
    check("ar_page_rd", 16'(d), 16'h0000);
    bus_idle();
    oam_cnt = 0;
    repeat (200) tick();
    check("ar_no_oamwr", 16'(oam_cnt), 16'd0);

    // Neighbouring registers FF45/FF47: no start, no drive
    set_wr(16'hFF45, 8'hC1); tick(); bus_idle(); samp();
    check("ff45_no_start", 16'(dma_active), 16'h0);
    set_wr(16'hFF47, 8'hC1); tick(); bus_idle(); samp();
    check("ff47_no_start", 16'(dma_active), 16'h0);
    tick(); samp();
    check("ff47_no_rd", 16'(dma_rd), 16'h0);
    set_rd(16'hFF45); samp();
    check("ff45_hiz", 16'(d), 16'h00FF);
    tick(); set_rd(16'hFF47); samp();
    check("ff47_hiz", 16'(d), 16'h00FF);
    tick(); set_rd(16'hFF46); samp();
    check("ff4x_page_kept", 16'(d), 16'h0000);
    bus_idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
